// File: rtl/scr1_mem_arb.sv
// -----------------------------------------------------------------------------
// scr1_mem_arb
//   Arbitrates the instruction-fetch (imem) and data (dmem) request ports of a
//   core onto one shared memory port.  Only one transaction is outstanding at a
//   time.  The FSM moves IDLE -> (REQ) -> RESP -> IDLE.  An owner register
//   records which side holds the shared port.
//
//   Parameter
//     RESP_TIMEOUT  number of RESP cycles before an error response (2'b10) is
//                   returned to the owner; 0 disables the timeout.
//
//   Build option
//     SCR1_MEM_ARB_RR_EN  when defined, a request tie is resolved round-robin
//                         via a last-grant flag.  When undefined, dmem always
//                         wins a tie.
//
//   Ports
//     clk, rst_n                       clock, async active-low reset
//     imem_req/cmd/addr                fetch request (always word, no wdata)
//     imem_req_ack/rdata/resp          fetch accept and response
//     dmem_req/cmd/width/addr/wdata    data request
//     dmem_req_ack/rdata/resp          data accept and response
//     mem_req/cmd/width/addr/wdata     shared-port request
//     mem_req_ack/rdata/resp           shared-port accept and response
//   Response encoding: 00 idle, 01 ready, 10 error.
// -----------------------------------------------------------------------------
module scr1_mem_arb #(
    parameter int RESP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        imem_req,
    input  logic        imem_cmd,
    input  logic [31:0] imem_addr,
    output logic        imem_req_ack,
    output logic [31:0] imem_rdata,
    output logic [1:0]  imem_resp,
    input  logic        dmem_req,
    input  logic        dmem_cmd,
    input  logic [1:0]  dmem_width,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic        dmem_req_ack,
    output logic [31:0] dmem_rdata,
    output logic [1:0]  dmem_resp,
    output logic        mem_req,
    output logic        mem_cmd,
    output logic [1:0]  mem_width,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_req_ack,
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  mem_resp
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;

    localparam logic OWN_IMEM = 1'b0;
    localparam logic OWN_DMEM = 1'b1;

    localparam int              CNT_W    = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESP_TIMEOUT - 1);
    localparam logic            TO_EN    = (RESP_TIMEOUT != 0);

    state_t           state_reg;
    logic             owner_reg;
    logic [CNT_W-1:0] cnt_reg;
`ifdef SCR1_MEM_ARB_RR_EN
    logic             last_grant_reg;
`endif

    logic       any_req;
    logic       winner;
    logic       grant_owner;
    logic       req_phase;
    logic       in_resp;
    logic       timeout_hit;
    logic [1:0] resp_eff;
    logic       resp_done;

    always_comb begin
        any_req = imem_req | dmem_req;
`ifdef SCR1_MEM_ARB_RR_EN
        // On a tie, grant whichever side was not granted last.
        winner = (dmem_req && (!imem_req || last_grant_reg == OWN_IMEM)) ? OWN_DMEM : OWN_IMEM;
`else
        winner = dmem_req ? OWN_DMEM : OWN_IMEM;
`endif
        // Arbitration only happens in IDLE; in REQ the latched owner is held.
        grant_owner = (state_reg == ST_IDLE) ? winner : owner_reg;
        // Outputs are gated by rst_n so they read 0 while reset is asserted,
        // even though request inputs feed them combinationally.
        req_phase   = rst_n && ((state_reg == ST_IDLE && any_req) || state_reg == ST_REQ);
        in_resp     = rst_n && (state_reg == ST_RESP);
        timeout_hit = TO_EN && in_resp && (cnt_reg == CNT_LAST) && (mem_resp == 2'b00);
        resp_eff    = timeout_hit ? 2'b10 : mem_resp;
        resp_done   = in_resp && (resp_eff != 2'b00);
    end

    always_comb begin
        mem_req      = req_phase;
        mem_cmd      = 1'b0;
        mem_width    = 2'b00;
        mem_addr     = 32'h0;
        mem_wdata    = 32'h0;
        imem_req_ack = 1'b0;
        dmem_req_ack = 1'b0;
        imem_rdata   = 32'h0;
        dmem_rdata   = 32'h0;
        imem_resp    = 2'b00;
        dmem_resp    = 2'b00;

        if (req_phase) begin
            if (grant_owner == OWN_DMEM) begin
                mem_cmd      = dmem_cmd;
                mem_width    = dmem_width;
                mem_addr     = dmem_addr;
                mem_wdata    = dmem_wdata;
                dmem_req_ack = mem_req_ack;
            end else begin
                mem_cmd      = imem_cmd;
                mem_width    = 2'b10;
                mem_addr     = imem_addr;
                imem_req_ack = mem_req_ack;
            end
        end

        if (in_resp) begin
            if (owner_reg == OWN_DMEM) begin
                dmem_rdata = mem_rdata;
                dmem_resp  = resp_eff;
            end else begin
                imem_rdata = mem_rdata;
                imem_resp  = resp_eff;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= OWN_IMEM;
            cnt_reg        <= '0;
`ifdef SCR1_MEM_ARB_RR_EN
            last_grant_reg <= OWN_IMEM;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (any_req) begin
                        owner_reg <= winner;
                        cnt_reg   <= '0;
                        if (mem_req_ack) begin
                            state_reg      <= ST_RESP;
`ifdef SCR1_MEM_ARB_RR_EN
                            last_grant_reg <= winner;
`endif
                        end else begin
                            state_reg <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // mem_resp is ignored here so a stale response is dropped.
                    if (mem_req_ack) begin
                        state_reg      <= ST_RESP;
                        cnt_reg        <= '0;
`ifdef SCR1_MEM_ARB_RR_EN
                        last_grant_reg <= owner_reg;
`endif
                    end
                end
                ST_RESP: begin
                    if (resp_done) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scr1_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_scr1_mem_arb
//   Directed self-checking bench for scr1_mem_arb with RESP_TIMEOUT = 4.
//   Inputs change 1 ns after the rising edge.  Outputs are checked mid-cycle.
//   Tie expectations follow SCR1_MEM_ARB_RR_EN if the bench is built with it.
// -----------------------------------------------------------------------------
module tb_scr1_mem_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_cmd;
    logic [31:0] imem_addr;
    logic        imem_req_ack;
    logic [31:0] imem_rdata;
    logic [1:0]  imem_resp;
    logic        dmem_req, dmem_cmd;
    logic [1:0]  dmem_width;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_req_ack;
    logic [31:0] dmem_rdata;
    logic [1:0]  dmem_resp;
    logic        mem_req, mem_cmd;
    logic [1:0]  mem_width;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_req_ack;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_resp;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    scr1_mem_arb #(.RESP_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_cmd(imem_cmd), .imem_addr(imem_addr),
        .imem_req_ack(imem_req_ack), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_req_ack(dmem_req_ack), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .mem_req(mem_req), .mem_cmd(mem_cmd), .mem_width(mem_width),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_req_ack(mem_req_ack), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic clr_inputs();
        imem_req = 0; imem_cmd = 0; imem_addr = 0;
        dmem_req = 0; dmem_cmd = 0; dmem_width = 0; dmem_addr = 0; dmem_wdata = 0;
        mem_req_ack = 0; mem_rdata = 0; mem_resp = 0;
    endtask

    task automatic set_tie();
        imem_req = 1; imem_cmd = 0; imem_addr = 32'h300;
        dmem_req = 1; dmem_cmd = 1; dmem_width = 2'b01;
        dmem_addr = 32'h1000; dmem_wdata = 32'h12345678;
    endtask

    logic exp_d;

    initial begin
        clr_inputs();
        rst_n = 0;
        imem_req = 1;            // outputs must stay 0 during reset
        #3;
        $display("txn reset: checking outputs held at 0");
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_imem_ack", {31'b0, imem_req_ack}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        next_cycle();
        next_cycle();
        rst_n = 1;
        clr_inputs();

        // Single imem read with response two cycles after the grant.
        imem_req = 1; imem_addr = 32'h200; mem_req_ack = 1;
        settle();
        $display("txn imem read addr=0x200");
        chk("t1_mem_req", {31'b0, mem_req}, 32'h1);
        chk("t1_mem_addr", mem_addr, 32'h200);
        chk("t1_mem_width", {30'b0, mem_width}, 32'h2);
        chk("t1_mem_wdata", mem_wdata, 32'h0);
        chk("t1_imem_ack", {31'b0, imem_req_ack}, 32'h1);
        chk("t1_dmem_ack", {31'b0, dmem_req_ack}, 32'h0);
        next_cycle();
        clr_inputs();
        settle();
        chk("t1_resp_mem_req", {31'b0, mem_req}, 32'h0);
        chk("t1_resp_wait", {30'b0, imem_resp}, 32'h0);
        next_cycle();
        mem_resp = 2'b01; mem_rdata = 32'hDEADBEEF;
        settle();
        chk("t1_imem_resp", {30'b0, imem_resp}, 32'h1);
        chk("t1_imem_rdata", imem_rdata, 32'hDEADBEEF);
        chk("t1_dmem_resp", {30'b0, dmem_resp}, 32'h0);
        chk("t1_dmem_rdata", dmem_rdata, 32'h0);
        next_cycle();
        clr_inputs();

        // Tie: dmem wins first, imem is served after the dmem response.
        set_tie(); mem_req_ack = 1;
        settle();
        $display("txn tie: dmem write addr=0x1000 vs imem addr=0x300");
        chk("t2_dmem_ack", {31'b0, dmem_req_ack}, 32'h1);
        chk("t2_imem_ack", {31'b0, imem_req_ack}, 32'h0);
        chk("t2_mem_addr", mem_addr, 32'h1000);
        chk("t2_mem_cmd", {31'b0, mem_cmd}, 32'h1);
        chk("t2_mem_width", {30'b0, mem_width}, 32'h1);
        chk("t2_mem_wdata", mem_wdata, 32'h12345678);
        next_cycle();
        dmem_req = 0; mem_req_ack = 0; mem_resp = 2'b01; mem_rdata = 32'h0000A5A5;
        settle();
        chk("t2_dmem_resp", {30'b0, dmem_resp}, 32'h1);
        chk("t2_dmem_rdata", dmem_rdata, 32'h0000A5A5);
        chk("t2_imem_resp", {30'b0, imem_resp}, 32'h0);
        chk("t2_imem_rdata", imem_rdata, 32'h0);
        next_cycle();
        mem_resp = 0; mem_rdata = 0; mem_req_ack = 1;
        settle();
        $display("txn tie: imem follow-up addr=0x300");
        chk("t2b_imem_ack", {31'b0, imem_req_ack}, 32'h1);
        chk("t2b_mem_addr", mem_addr, 32'h300);
        chk("t2b_mem_width", {30'b0, mem_width}, 32'h2);
        next_cycle();
        clr_inputs(); mem_resp = 2'b01;
        next_cycle();
        clr_inputs();

        // Four back-to-back ties. The last grant was imem, so RR starts with dmem.
        for (int i = 0; i < 4; i++) begin
`ifdef SCR1_MEM_ARB_RR_EN
            exp_d = (i % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            set_tie(); mem_req_ack = 1;
            settle();
            $display("txn tie round %0d: expect %s", i, exp_d ? "dmem" : "imem");
            chk("t3_dmem_ack", {31'b0, dmem_req_ack}, {31'b0, exp_d});
            chk("t3_imem_ack", {31'b0, imem_req_ack}, {31'b0, ~exp_d});
            chk("t3_mem_addr", mem_addr, exp_d ? 32'h1000 : 32'h300);
            next_cycle();
            clr_inputs(); mem_resp = 2'b01; mem_rdata = 32'h100 + i;
            settle();
            chk("t3_dmem_resp", {30'b0, dmem_resp}, exp_d ? 32'h1 : 32'h0);
            chk("t3_imem_resp", {30'b0, imem_resp}, exp_d ? 32'h0 : 32'h1);
            next_cycle();
            clr_inputs();
        end

        // Stalled grant: imem holds the port while dmem_req rises.
        imem_req = 1; imem_addr = 32'h400;
        settle();
        $display("txn stall: imem addr=0x400 with ack held low");
        chk("t4_c1_mem_req", {31'b0, mem_req}, 32'h1);
        chk("t4_c1_imem_ack", {31'b0, imem_req_ack}, 32'h0);
        for (int c = 2; c <= 3; c++) begin
            next_cycle();
            dmem_req = 1; dmem_addr = 32'h2000; dmem_width = 2'b00; dmem_wdata = 32'hFF;
            mem_resp = 2'b01;   // stray response in REQ must be ignored
            settle();
            chk("t4_mem_req", {31'b0, mem_req}, 32'h1);
            chk("t4_mem_addr", mem_addr, 32'h400);
            chk("t4_mem_width", {30'b0, mem_width}, 32'h2);
            chk("t4_dmem_ack", {31'b0, dmem_req_ack}, 32'h0);
            chk("t4_imem_resp", {30'b0, imem_resp}, 32'h0);
        end
        next_cycle();
        mem_resp = 0; mem_req_ack = 1;
        settle();
        chk("t4_c4_imem_ack", {31'b0, imem_req_ack}, 32'h1);
        chk("t4_c4_dmem_ack", {31'b0, dmem_req_ack}, 32'h0);
        chk("t4_c4_mem_addr", mem_addr, 32'h400);
        next_cycle();
        clr_inputs(); mem_resp = 2'b01;
        next_cycle();
        clr_inputs();

        // Timeout: no response, error in the 4th RESP cycle, late response dropped.
        imem_req = 1; imem_addr = 32'h500; mem_req_ack = 1;
        settle();
        $display("txn timeout: imem addr=0x500, no response");
        chk("t5_imem_ack", {31'b0, imem_req_ack}, 32'h1);
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            clr_inputs();
            settle();
            chk("t5_wait_resp", {30'b0, imem_resp}, 32'h0);
        end
        next_cycle();
        settle();
        chk("t5_err_resp", {30'b0, imem_resp}, 32'h2);
        chk("t5_err_dmem_resp", {30'b0, dmem_resp}, 32'h0);
        next_cycle();
        mem_resp = 2'b01; mem_rdata = 32'hBAD;
        settle();
        chk("t5_late_imem_resp", {30'b0, imem_resp}, 32'h0);
        chk("t5_late_mem_req", {31'b0, mem_req}, 32'h0);
        next_cycle();
        clr_inputs();

        // Reset asserted mid-RESP.
        imem_req = 1; imem_addr = 32'h600; mem_req_ack = 1;
        next_cycle();
        clr_inputs(); imem_req = 1; imem_addr = 32'h600;
        mem_resp = 2'b01; mem_rdata = 32'hCAFE;
        #2;
        $display("txn reset during RESP");
        chk("t6_pre_resp", {30'b0, imem_resp}, 32'h1);
        rst_n = 0;
        #1;
        chk("t6_rst_resp", {30'b0, imem_resp}, 32'h0);
        chk("t6_rst_rdata", imem_rdata, 32'h0);
        chk("t6_rst_mem_req", {31'b0, mem_req}, 32'h0);
        next_cycle();
        rst_n = 1;
        imem_req = 0;
        settle();
        chk("t6_idle_resp", {30'b0, imem_resp}, 32'h0);
        next_cycle();
        imem_req = 1; mem_req_ack = 1; mem_resp = 0;
        settle();
        chk("t6_idle_grant", {31'b0, imem_req_ack}, 32'h1);
        chk("t6_idle_addr", mem_addr, 32'h600);
        next_cycle();
        clr_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scr1_mem_arb.md
SCR1_MEM_ARB -- requirements
Module: scr1_mem_arb

Interface
REQ-001 Parameter: RESP_TIMEOUT, 255, cycles in response phase before an error response is returned; 0 disables the timeout.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 imem_req  input  1  instruction-fetch request.
REQ-005 imem_cmd  input  1  0 = read, 1 = write.
REQ-006 imem_addr  input  32  fetch address.
REQ-007 imem_req_ack  output  1  imem request accepted.
REQ-008 imem_rdata  output  32  fetch read data.
REQ-009 imem_resp  output  2  00 idle, 01 ready, 10 error.
REQ-010 dmem_req  input  1  data request.
REQ-011 dmem_cmd  input  1  0 = read, 1 = write.
REQ-012 dmem_width  input  2  00 byte, 01 half, 10 word.
REQ-013 dmem_addr  input  32  data address.
REQ-014 dmem_wdata  input  32  write data.
REQ-015 dmem_req_ack  output  1  dmem request accepted.
REQ-016 dmem_rdata  output  32  data read data.
REQ-017 dmem_resp  output  2  same encoding as imem_resp.
REQ-018 mem_req, mem_cmd, mem_width[2], mem_addr[32], mem_wdata[32]  outputs  shared-port request fields.
REQ-019 mem_req_ack  input  1, mem_rdata  input  32, mem_resp  input  2  shared-port acknowledge and response.

Function
REQ-020 The block SHALL implement the FSM states IDLE, REQ and RESP, plus an owner register (IMEM/DMEM).
REQ-021 In IDLE with any request active, the block SHALL pick a winner combinationally, drive mem_req=1 with the winner's fields in the same cycle, and latch the owner.
REQ-022 If mem_req_ack=0, the block SHALL go to REQ, holding the owner (no re-arbitration) and driving the latched owner's live fields until mem_req_ack=1.
REQ-023 On mem_req_ack=1 (in IDLE or REQ), the block SHALL pulse the owner's req_ack the same cycle and enter RESP; the non-owner's req_ack SHALL stay 0.
REQ-024 For an imem grant, the block SHALL drive mem_width=10 and mem_wdata=0.
REQ-025 In RESP, mem_req SHALL be 0; mem_rdata/mem_resp SHALL route to the owner only; the non-owner's resp SHALL be 00.
REQ-026 When mem_resp≠00 in RESP, the block SHALL return to IDLE; the next grant comes no earlier than the following cycle (one transaction outstanding).
REQ-027 The block SHALL count RESP cycles; on reaching RESP_TIMEOUT (≠0) with mem_resp=00, it SHALL drive owner resp=10 for one cycle and go to IDLE.
REQ-028 mem_resp SHALL be ignored in IDLE and REQ, so late responses are dropped.
REQ-029 When both requests are active in IDLE, the default priority SHALL be dmem over imem.

Reset
REQ-030 On rst_n=0 (any state, including mid-transaction), the block SHALL enter IDLE asynchronously, clear owner, the counter and the RR flag, and drive all outputs to 0.
REQ-031 After reset release, the first arbitration SHALL occur on the first rising clk edge with rst_n=1.

Configuration
REQ-032 With SCR1_MEM_ARB_RR_EN defined, the block SHALL arbitrate ties round-robin using a last_grant flag (reset = IMEM, updated on each mem_req_ack), granting the requester not granted last; without the macro, fixed dmem priority SHALL apply.

Verification
REQ-033 imem_req only, addr 0x200, ack same cycle, resp=01 rdata 0xDEADBEEF two cycles later -> imem_req_ack pulse, imem_resp=01 with 0xDEADBEEF, dmem_resp=00.
REQ-034 imem_req and dmem_req together, no RR macro -> dmem granted first (width/wdata passed); imem granted after dmem resp=01.
REQ-035 Same stimulus with SCR1_MEM_ARB_RR_EN, repeated 4 times -> grants alternate D,I,D,I.
REQ-036 mem_req_ack held 0 for 3 cycles while dmem_req rises -> mem fields stay imem's, no dmem_req_ack; imem acked in cycle 4.
REQ-037 RESP_TIMEOUT=4, mem_resp stays 00 -> owner resp=10 in the 4th RESP cycle; a late resp=01 is ignored.
REQ-038 rst_n asserted in RESP -> outputs 0 immediately; IDLE after release.
